// File: rtl/alu_flag_register.sv
// Architectural flag register fed by the ALU. It also evaluates branch conditions and
// keeps a small LIFO of saved flag words for interrupt entry and return.
module alu_flag_register #(
  parameter int STACK_DEPTH = 4,
  parameter int DW          = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ALU_SIGN,
  input  logic          ALU_CARRY,
  input  logic          ALU_ZERO,
  input  logic          ALU_PARITY,
  input  logic          LOAD_FLAGS,
  input  logic          WR_FLAGS,
  input  logic [3:0]    WR_DATA,
  input  logic          PUSH,
  input  logic          POP,
  input  logic          ERR_CLR,
  input  logic [3:0]    CC,
  output logic [3:0]    FLAGS,
  output logic          COND_TRUE,
  output logic          STACK_EMPTY,
  output logic          STACK_FULL,
  output logic [DW-1:0] DEPTH,
  output logic          STACK_ERR
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL_CNT = DW'(STACK_DEPTH);
  localparam logic [DW-1:0] ONE_D    = 1;
  localparam logic [AW-1:0] ONE_A    = 1;

  logic [3:0]    flags_q;
  logic [DW-1:0] depth_q;
  logic          err_q;
  logic [3:0]    stack_mem [STACK_DEPTH];

  logic          empty;
  logic          full;
  logic          push_ok;
  logic          pop_ok;
  logic          stack_fault;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign empty   = (depth_q == '0);
  assign full    = (depth_q == FULL_CNT);
  assign wr_idx  = depth_q[AW-1:0];
  assign top_idx = wr_idx - ONE_A;

  // PUSH and POP together cancel out: no stack movement and no error.
  assign push_ok     = PUSH & ~POP & ~full;
  assign pop_ok      = POP & ~PUSH & ~empty;
  assign stack_fault = (PUSH & ~POP & full) | (POP & ~PUSH & empty);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flags_q <= 4'b0000;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // A successful restore outranks any software write or ALU load.
      if (pop_ok)
        flags_q <= stack_mem[top_idx];
      else if (WR_FLAGS)
        flags_q <= WR_DATA;
      else if (LOAD_FLAGS)
        flags_q <= {ALU_SIGN, ALU_CARRY, ALU_ZERO, ALU_PARITY};

      if (push_ok)
        depth_q <= depth_q + ONE_D;
      else if (pop_ok)
        depth_q <= depth_q - ONE_D;

      if (stack_fault)
        err_q <= 1'b1;
      else if (ERR_CLR)
        err_q <= 1'b0;
    end
  end

  // Saved words are not reset; the depth counter alone defines what is valid.
  always_ff @(posedge CLK) begin
    if (push_ok)
      stack_mem[wr_idx] <= flags_q;
  end

  always_comb begin
    COND_TRUE = 1'b0;
    case (CC)
      4'd0:    COND_TRUE = 1'b1;
      4'd1:    COND_TRUE = flags_q[1];
      4'd2:    COND_TRUE = ~flags_q[1];
      4'd3:    COND_TRUE = flags_q[2];
      4'd4:    COND_TRUE = ~flags_q[2];
      4'd5:    COND_TRUE = flags_q[3];
      4'd6:    COND_TRUE = ~flags_q[3];
      4'd7:    COND_TRUE = flags_q[0];
      4'd8:    COND_TRUE = ~flags_q[0];
      4'd9:    COND_TRUE = flags_q[2];
      4'd10:   COND_TRUE = ~flags_q[2];
      4'd11:   COND_TRUE = flags_q[2] | flags_q[1];
      4'd12:   COND_TRUE = ~flags_q[2] & ~flags_q[1];
      default: COND_TRUE = 1'b0;
    endcase
  end

  assign FLAGS       = flags_q;
  assign DEPTH       = depth_q;
  assign STACK_EMPTY = empty;
  assign STACK_FULL  = full;
  assign STACK_ERR   = err_q;

endmodule

// File: tb/tb_alu_flag_register.sv
// Directed bench for alu_flag_register: vector table for flag/stack sequences,
// condition-code sweeps and a reset-in-the-middle sequence.
module tb_alu_flag_register;

  logic       clk;
  logic       reset;
  logic       alu_sign, alu_carry, alu_zero, alu_parity;
  logic       load_flags, wr_flags, push, pop, err_clr;
  logic [3:0] wr_data;
  logic [3:0] cc;
  logic [3:0] flags;
  logic       cond_true, stack_empty, stack_full, stack_err;
  logic [2:0] depth;

  int checks   = 0;
  int failures = 0;

  // Expected word: {flags[3:0], depth[2:0], empty, full, err, cond}
  logic [10:0] exp_q[$];

  typedef struct {
    logic       wr, load, psh, pp, clr;
    logic [3:0] wd, alu, cc;
    logic [3:0] e_flags;
    logic [2:0] e_depth;
    logic       e_err, e_cond;
  } vec_t;

  vec_t vecs[30];

  alu_flag_register #(.STACK_DEPTH(4), .DW(3)) dut (
    .CLK(clk), .RESET(reset),
    .ALU_SIGN(alu_sign), .ALU_CARRY(alu_carry), .ALU_ZERO(alu_zero), .ALU_PARITY(alu_parity),
    .LOAD_FLAGS(load_flags), .WR_FLAGS(wr_flags), .WR_DATA(wr_data),
    .PUSH(push), .POP(pop), .ERR_CLR(err_clr), .CC(cc),
    .FLAGS(flags), .COND_TRUE(cond_true), .STACK_EMPTY(stack_empty),
    .STACK_FULL(stack_full), .DEPTH(depth), .STACK_ERR(stack_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic wr, logic load, logic psh, logic pp, logic clr,
                              logic [3:0] wd, logic [3:0] alu, logic [3:0] c,
                              logic [3:0] ef, logic [2:0] ed, logic ee, logic ec);
    vec_t v;
    v.wr = wr; v.load = load; v.psh = psh; v.pp = pp; v.clr = clr;
    v.wd = wd; v.alu = alu; v.cc = c;
    v.e_flags = ef; v.e_depth = ed; v.e_err = ee; v.e_cond = ec;
    return v;
  endfunction

  function automatic logic [10:0] pack_exp(logic [3:0] f, logic [2:0] d, logic e, logic c);
    return {f, d, (d == 3'd0), (d == 3'd4), e, c};
  endfunction

  // Driver tasks
  task automatic idle();
    {alu_sign, alu_carry, alu_zero, alu_parity} = 4'b0000;
    load_flags = 1'b0; wr_flags = 1'b0; wr_data = 4'b0000;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    wr_flags = v.wr; load_flags = v.load; push = v.psh; pop = v.pp; err_clr = v.clr;
    wr_data = v.wd;
    {alu_sign, alu_carry, alu_zero, alu_parity} = v.alu;
    cc = v.cc;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare the DUT against the oldest queued expectation.
  task automatic sb_check(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".flags"}, flags,              e[10:7]);
      check({tag, ".depth"}, {1'b0, depth},      {1'b0, e[6:4]});
      check({tag, ".empty"}, {3'b0, stack_empty}, {3'b0, e[3]});
      check({tag, ".full"},  {3'b0, stack_full},  {3'b0, e[2]});
      check({tag, ".err"},   {3'b0, stack_err},   {3'b0, e[1]});
      check({tag, ".cond"},  {3'b0, cond_true},   {3'b0, e[0]});
    end
  endtask

  task automatic write_flags(input logic [3:0] d);
    idle(); wr_flags = 1'b1; wr_data = d;
    step();
    idle();
  endtask

  // Sweep CC 0..15; bit i of table is the required COND_TRUE for CC=i.
  task automatic cc_sweep(input logic [3:0] f, input logic [15:0] table_bits);
    write_flags(f);
    check("sweep.flags", flags, f);
    for (int i = 0; i < 16; i++) begin
      cc = 4'(i);
      #1;
      check($sformatf("sweep_%b.cc%0d", f, i), {3'b0, cond_true}, {3'b0, table_bits[i]});
    end
  endtask

  initial begin
    vecs[0]  = mk(0,1,0,0,0, 4'b0000,4'b1010, 4'd1,  4'b1010,3'd0,0,1);
    vecs[1]  = mk(1,0,0,0,0, 4'b0000,4'b0000, 4'd2,  4'b0000,3'd0,0,1);
    vecs[2]  = mk(1,1,0,0,0, 4'b0110,4'b1001, 4'd11, 4'b0110,3'd0,0,1);
    vecs[3]  = mk(1,0,0,0,0, 4'b0001,4'b0000, 4'd7,  4'b0001,3'd0,0,1);
    vecs[4]  = mk(0,0,1,0,0, 4'b0000,4'b0000, 4'd12, 4'b0001,3'd1,0,1);
    vecs[5]  = mk(1,0,0,0,0, 4'b0100,4'b0000, 4'd9,  4'b0100,3'd1,0,1);
    vecs[6]  = mk(0,0,1,0,0, 4'b0000,4'b0000, 4'd10, 4'b0100,3'd2,0,0);
    vecs[7]  = mk(0,0,0,1,0, 4'b0000,4'b0000, 4'd4,  4'b0100,3'd1,0,0);
    vecs[8]  = mk(0,0,0,1,0, 4'b0000,4'b0000, 4'd8,  4'b0001,3'd0,0,0);
    vecs[9]  = mk(1,0,1,0,0, 4'b0010,4'b0000, 4'd1,  4'b0010,3'd1,0,1);
    vecs[10] = mk(1,0,1,0,0, 4'b0011,4'b0000, 4'd8,  4'b0011,3'd2,0,0);
    vecs[11] = mk(1,0,1,0,0, 4'b0100,4'b0000, 4'd3,  4'b0100,3'd3,0,1);
    vecs[12] = mk(1,0,1,0,0, 4'b0101,4'b0000, 4'd7,  4'b0101,3'd4,0,1);
    vecs[13] = mk(1,0,1,0,0, 4'b0110,4'b0000, 4'd12, 4'b0110,3'd4,1,0);
    vecs[14] = mk(0,0,0,0,1, 4'b0000,4'b0000, 4'd13, 4'b0110,3'd4,0,0);
    vecs[15] = mk(0,0,0,1,0, 4'b0000,4'b0000, 4'd11, 4'b0100,3'd3,0,1);
    vecs[16] = mk(0,0,0,1,0, 4'b0000,4'b0000, 4'd2,  4'b0011,3'd2,0,0);
    vecs[17] = mk(0,0,0,1,0, 4'b0000,4'b0000, 4'd6,  4'b0010,3'd1,0,1);
    vecs[18] = mk(0,0,0,1,0, 4'b0000,4'b0000, 4'd5,  4'b0001,3'd0,0,0);
    vecs[19] = mk(0,0,0,1,0, 4'b0000,4'b0000, 4'd0,  4'b0001,3'd0,1,1);
    vecs[20] = mk(0,1,0,1,0, 4'b0000,4'b1100, 4'd5,  4'b1100,3'd0,1,1);
    vecs[21] = mk(0,0,0,1,1, 4'b0000,4'b0000, 4'd14, 4'b1100,3'd0,1,0);
    vecs[22] = mk(0,0,0,0,1, 4'b0000,4'b0000, 4'd6,  4'b1100,3'd0,0,0);
    vecs[23] = mk(1,0,0,0,0, 4'b0100,4'b0000, 4'd9,  4'b0100,3'd0,0,1);
    vecs[24] = mk(0,1,1,0,0, 4'b0000,4'b1000, 4'd5,  4'b1000,3'd1,0,1);
    vecs[25] = mk(1,0,0,1,0, 4'b1111,4'b0000, 4'd12, 4'b0100,3'd0,0,0);
    vecs[26] = mk(1,0,1,1,0, 4'b1010,4'b0000, 4'd2,  4'b1010,3'd0,0,0);
    vecs[27] = mk(0,0,1,0,0, 4'b0000,4'b0000, 4'd1,  4'b1010,3'd1,0,1);
    vecs[28] = mk(0,1,1,1,0, 4'b0000,4'b0001, 4'd15, 4'b0001,3'd1,0,0);
    vecs[29] = mk(0,0,0,1,0, 4'b0000,4'b0000, 4'd4,  4'b1010,3'd0,0,1);

    idle();
    cc = 4'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.push_back(pack_exp(4'b0000, 3'd0, 1'b0, 1'b1));
    sb_check("reset");

    for (int i = 0; i < 30; i++) begin
      drive_vec(vecs[i]);
      exp_q.push_back(pack_exp(vecs[i].e_flags, vecs[i].e_depth, vecs[i].e_err, vecs[i].e_cond));
      step();
      sb_check($sformatf("vec%0d", i));
      idle();
    end

    cc_sweep(4'b0000, 16'h1555);
    cc_sweep(4'b0100, 16'h0B4D);
    cc_sweep(4'b1111, 16'h0AAB);
    cc_sweep(4'b0010, 16'h0D53);

    // Reset in the middle of a saved sequence drops every saved word.
    cc = 4'd0;
    write_flags(4'b0111);
    push = 1'b1; step();
    push = 1'b1; step();
    idle();
    exp_q.push_back(pack_exp(4'b0111, 3'd2, 1'b0, 1'b1));
    sb_check("pre_reset");
    reset = 1'b1; push = 1'b1; wr_flags = 1'b1; wr_data = 4'b1111;
    step();
    reset = 1'b0;
    idle();
    exp_q.push_back(pack_exp(4'b0000, 3'd0, 1'b0, 1'b1));
    sb_check("mid_reset");
    pop = 1'b1;
    step();
    idle();
    exp_q.push_back(pack_exp(4'b0000, 3'd0, 1'b1, 1'b1));
    sb_check("pop_after_reset");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
